// File: rtl/pipelined_rca_pkg.sv
// Shared helpers for the pipelined ripple-carry adder.
// Slice width derivation and parameter sanity check.
package pipelined_rca_pkg;

  function automatic int chunk_w(int w, int s);
    return w / s;
  endfunction

  function automatic bit split_ok(int w, int s);
    return (s >= 1) && (s <= w) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Building block for the ripple slices.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// File: rtl/pipelined_rca_adder_slice.sv
// Combinational N-bit ripple adder slice.
// Also exposes the carry into its MSB for signed overflow.
module rca_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_s,
  output logic         o_cout,
  output logic         o_cmsb
);

  logic [N:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .i_a (i_a[i]),
      .i_b (i_b[i]),
      .i_ci(w_c[i]),
      .o_s (o_s[i]),
      .o_co(w_c[i+1])
    );
  end

  assign o_cout = w_c[N];
  assign o_cmsb = w_c[N-1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder with valid/ready back-pressure.
// Define PIPELINED_RCA_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_rca_adder
  import pipelined_rca_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_RCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipelined_rca_adder: WIDTH must be a multiple of STAGES");
  end

  logic w_adv;

  // Index k is the input of stage k; index k+1 is its register output.
  logic [WIDTH-1:0] w_a [STAGES+1];
  logic [WIDTH-1:0] w_b [STAGES+1];
  logic [WIDTH-1:0] w_s [STAGES+1];
  logic             w_c [STAGES+1];
  logic             w_v [STAGES+1];
  logic             w_cm [STAGES];

  assign w_adv    = !(out_valid && !out_ready);
  assign in_ready = w_adv;

  assign w_a[0] = a;
  assign w_b[0] = b;
  assign w_s[0] = '0;
  assign w_c[0] = cin;
  assign w_v[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [CHUNK-1:0] w_sl;
    logic             w_co;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_v;

    rca_slice #(.N(CHUNK)) u_slice (
      .i_a   (w_a[k][k*CHUNK +: CHUNK]),
      .i_b   (w_b[k][k*CHUNK +: CHUNK]),
      .i_cin (w_c[k]),
      .o_s   (w_sl),
      .o_cout(w_co),
      .o_cmsb(w_cm[k])
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        r_a <= '0;
        r_b <= '0;
        r_s <= '0;
        r_c <= 1'b0;
        r_v <= 1'b0;
      end else if (w_adv) begin
        r_a <= w_a[k];
        r_b <= w_b[k];
        r_s <= w_s[k];
        r_s[k*CHUNK +: CHUNK] <= w_sl;
        r_c <= w_co;
        r_v <= w_v[k];
      end
    end

    assign w_a[k+1] = r_a;
    assign w_b[k+1] = r_b;
    assign w_s[k+1] = r_s;
    assign w_c[k+1] = r_c;
    assign w_v[k+1] = r_v;
  end

  assign sum       = w_s[STAGES];
  assign cout      = w_c[STAGES];
  assign out_valid = w_v[STAGES];

`ifdef PIPELINED_RCA_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_cm[STAGES-1] ^ g_st[STAGES-1].w_co;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
